// File: rtl/iddrx4_align_ctl.sv
// Bit-slip word-alignment sequencer for a 1:8 DDR input gearbox (SCLK domain).
// Slips until MATCH_CNT consecutive training words match, then optionally monitors lock.
module iddrx4_align_ctl #(
    parameter logic [7:0] PATTERN    = 8'hB4,
    parameter int         MATCH_CNT  = 4,
    parameter int         SETTLE_CYC = 4,
    parameter int         PULSE_W    = 2,
    parameter int         MAX_SLIP   = 8,
    parameter int         ERR_LIMIT  = 3
) (
    input  logic       i_sclk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_monitor,
    input  logic [7:0] i_q,
    output logic       o_alignwd,
    output logic       o_locked,
    output logic       o_fail,
    output logic [3:0] o_slips,
    output logic [2:0] o_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_CHECK  = 3'd2,
        ST_SLIP   = 3'd3,
        ST_LOCKED = 3'd4,
        ST_FAIL   = 3'd5
    } state_t;

    localparam logic [3:0] LP_MATCH  = 4'(MATCH_CNT);
    localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYC);
    localparam logic [3:0] LP_PULSE  = 4'(PULSE_W);
    localparam logic [3:0] LP_MAX    = 4'(MAX_SLIP);
    localparam logic [3:0] LP_ERR    = 4'(ERR_LIMIT);

    state_t     r_state;
    logic [3:0] r_scnt;
    logic [3:0] r_mcnt;
    logic [3:0] r_pcnt;
    logic [3:0] r_ecnt;
    logic [3:0] r_slips;
    logic       r_alignwd;
    logic       r_locked;
    logic       r_fail;
    logic       w_match;

    // Case equality so any X/Z bit on the gearbox word is treated as a mismatch.
    assign w_match = (i_q === PATTERN);

    // NOTE: sequential state uses non-blocking assignments only, so every branch
    // below sees the register values from before this edge.
    always_ff @(posedge i_sclk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_scnt    <= '0;
            r_mcnt    <= '0;
            r_pcnt    <= '0;
            r_ecnt    <= '0;
            r_slips   <= '0;
            r_alignwd <= 1'b0;
            r_locked  <= 1'b0;
            r_fail    <= 1'b0;
        end else if (!i_en) begin
            // Abort wins over every transition and cuts any pulse in flight.
            r_state   <= ST_IDLE;
            r_scnt    <= '0;
            r_mcnt    <= '0;
            r_pcnt    <= '0;
            r_ecnt    <= '0;
            r_slips   <= '0;
            r_alignwd <= 1'b0;
            r_locked  <= 1'b0;
            r_fail    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_SETTLE;
                    r_scnt  <= LP_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_scnt <= 4'd1) begin
                        r_scnt  <= '0;
                        r_mcnt  <= '0;
                        r_state <= ST_CHECK;
                    end else begin
                        r_scnt <= r_scnt - 4'd1;
                    end
                end
                ST_CHECK: begin
                    if (w_match) begin
                        r_mcnt <= r_mcnt + 4'd1;
                        if (r_mcnt + 4'd1 >= LP_MATCH) r_state <= ST_LOCKED;
                    end else if (r_slips < LP_MAX) begin
                        r_mcnt    <= '0;
                        r_slips   <= r_slips + 4'd1;
                        r_alignwd <= 1'b1;
                        r_pcnt    <= LP_PULSE;
                        r_state   <= ST_SLIP;
                    end else begin
                        r_state <= ST_FAIL;
                    end
                end
                ST_SLIP: begin
                    if (r_pcnt <= 4'd1) begin
                        r_pcnt    <= '0;
                        r_alignwd <= 1'b0;
                        r_scnt    <= LP_SETTLE;
                        r_state   <= ST_SETTLE;
                    end else begin
                        r_pcnt <= r_pcnt - 4'd1;
                    end
                end
                ST_LOCKED: begin
                    if (i_monitor && !w_match && (r_ecnt + 4'd1 >= LP_ERR)) begin
                        r_locked <= 1'b0;
                        r_slips  <= '0;
                        r_mcnt   <= '0;
                        r_ecnt   <= '0;
                        r_state  <= ST_CHECK;
                    end else begin
                        r_locked <= 1'b1;
                        // Dropping MONITOR, or any good word, restarts the error run.
                        if (i_monitor && !w_match) r_ecnt <= r_ecnt + 4'd1;
                        else                       r_ecnt <= '0;
                    end
                end
                ST_FAIL: begin
                    r_fail <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_alignwd = r_alignwd;
    assign o_locked  = r_locked;
    assign o_fail    = r_fail;
    assign o_slips   = r_slips;
    assign o_state   = r_state;

endmodule

// File: tb/tb_iddrx4_align_ctl.sv
// Scoreboard bench for iddrx4_align_ctl with a rotating-gearbox model and an ALIGNWD pulse monitor.
module tb_iddrx4_align_ctl;

    localparam logic [7:0] PAT    = 8'hB4;
    localparam int         SETTLE = 4;

    logic       clk = 1'b0;
    logic       rst, en, mon;
    logic [7:0] q;
    logic       alignwd, locked, fail;
    logic [3:0] slips;
    logic [2:0] state;

    logic [7:0] q_const  = PAT;
    bit         gb_en    = 1'b0;
    bit         q_bad    = 1'b0;
    bit         mon_clr  = 1'b1;
    int         off_init = 0;

    int off = 0, pulse_cnt = 0, wmin = 99, wmax = 0, gap_min = 99, cur_w = 0, low_run = 0;
    bit prev_a = 1'b0;

    int    n_cmp = 0, n_bad = 0;
    int    exp_q[$];
    string tag_q[$];

    iddrx4_align_ctl dut (
        .i_sclk    (clk),
        .i_rst     (rst),
        .i_en      (en),
        .i_monitor (mon),
        .i_q       (q),
        .o_alignwd (alignwd),
        .o_locked  (locked),
        .o_fail    (fail),
        .o_slips   (slips),
        .o_state   (state)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] d;
        d = {v, v} << n;
        return d[15:8];
    endfunction

    assign q = q_bad ? 8'h00 : (gb_en ? rotl8(PAT, off) : q_const);

    // Gearbox shifts by one bit per ALIGNWD pulse; also collects pulse widths and gaps.
    always @(negedge clk) begin
        if (mon_clr) begin
            pulse_cnt = 0; wmin = 99; wmax = 0; gap_min = 99;
            cur_w = 0; low_run = 0; prev_a = 1'b0; off = off_init;
        end else begin
            if (alignwd && !prev_a) begin
                if (pulse_cnt > 0 && low_run < gap_min) gap_min = low_run;
                pulse_cnt++;
                cur_w = 1;
                off = (off + 7) % 8;
            end else if (alignwd) begin
                cur_w++;
            end else begin
                if (prev_a) begin
                    if (cur_w < wmin) wmin = cur_w;
                    if (cur_w > wmax) wmax = cur_w;
                    low_run = 0;
                end
                low_run++;
            end
            prev_a = alignwd;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input int v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic sb_cmp(input int obs);
        if (exp_q.size() == 0) begin
            check("sb_empty_pop", 0, 1);
        end else begin
            check(tag_q.pop_front(), obs, exp_q.pop_front());
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr_mon(input int o);
        off_init = o;
        mon_clr  = 1'b1;
        step(1);
        mon_clr  = 1'b0;
    endtask

    // which: 0 = locked, 1 = fail, 2 = alignwd
    task automatic wait_for(input string tag, input int which, input int budget);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            step(1);
            case (which)
                0:       hit = locked;
                1:       hit = fail;
                default: hit = alignwd;
            endcase
        end
        check(tag, int'(hit), 1);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mon = 1'b0;
        clr_mon(0);
        step(1);
        sb_push("rst_alignwd", 0); sb_push("rst_locked", 0); sb_push("rst_fail", 0);
        sb_push("rst_slips", 0);   sb_push("rst_state", 0);
        sb_cmp(alignwd); sb_cmp(locked); sb_cmp(fail); sb_cmp(slips); sb_cmp(state);
        rst = 1'b0;
        step(1);

        // T1: asynchronous reset in the middle of a slip pulse
        q_const = 8'h00; en = 1'b1;
        wait_for("t1_wait_pulse", 2, 50);
        sb_push("t1_alignwd", 0); sb_push("t1_state", 0); sb_push("t1_locked", 0); sb_push("t1_slips", 0);
        rst = 1'b1;
        #1;
        sb_cmp(alignwd); sb_cmp(state); sb_cmp(locked); sb_cmp(slips);
        en = 1'b0;
        step(1);
        rst = 1'b0;
        step(1);

        // T2: already aligned stream locks after a fixed latency with no slips
        q_const = PAT;
        clr_mon(0);
        sb_push("t2_lock_early", 0); sb_push("t2_lock", 1); sb_push("t2_slips", 0); sb_push("t2_pulses", 0);
        en = 1'b1;
        step(9);
        sb_cmp(locked);
        step(1);
        sb_cmp(locked); sb_cmp(slips); sb_cmp(pulse_cnt);

        // T3: gearbox offset by 3 bits
        en = 1'b0; step(1);
        gb_en = 1'b1;
        clr_mon(3);
        sb_push("t3_pulses", 3); sb_push("t3_wmin", 2); sb_push("t3_wmax", 2); sb_push("t3_gap_ok", 1);
        sb_push("t3_slips", 3);  sb_push("t3_locked", 1); sb_push("t3_fail", 0);
        en = 1'b1;
        wait_for("t3_wait_lock", 0, 300);
        sb_cmp(pulse_cnt); sb_cmp(wmin); sb_cmp(wmax); sb_cmp(int'(gap_min >= SETTLE + 1));
        sb_cmp(slips); sb_cmp(locked); sb_cmp(fail);

        // T4: pattern never appears
        en = 1'b0; step(1);
        gb_en = 1'b0; q_const = 8'h00;
        clr_mon(0);
        sb_push("t4_pulses", 8); sb_push("t4_fail", 1); sb_push("t4_slips", 8); sb_push("t4_locked", 0);
        sb_push("t4_fail_sticky", 1); sb_push("t4_slips_frozen", 8);
        sb_push("t4_abort_fail", 0); sb_push("t4_abort_state", 0); sb_push("t4_abort_slips", 0);
        en = 1'b1;
        wait_for("t4_wait_fail", 1, 400);
        sb_cmp(pulse_cnt); sb_cmp(fail); sb_cmp(slips); sb_cmp(locked);
        step(5);
        sb_cmp(fail); sb_cmp(slips);
        en = 1'b0;
        step(1);
        sb_cmp(fail); sb_cmp(state); sb_cmp(slips);

        // T5: lock monitoring with sporadic and sustained errors
        gb_en = 1'b1;
        clr_mon(2);
        mon = 1'b1;
        sb_push("t5_slips_locked", 2); sb_push("t5_hold_locked", 1); sb_push("t5_hold_state", 4);
        sb_push("t5_drop_locked", 0);  sb_push("t5_drop_state", 2);  sb_push("t5_drop_slips", 0);
        sb_push("t5_relock", 1);
        en = 1'b1;
        wait_for("t5_wait_lock", 0, 200);
        sb_cmp(slips);
        q_bad = 1'b1; step(2);
        q_bad = 1'b0; step(1);
        q_bad = 1'b1; step(2);
        mon = 1'b0;   step(1);
        mon = 1'b1;   step(2);
        q_bad = 1'b0; step(2);
        sb_cmp(locked); sb_cmp(state);
        q_bad = 1'b1; step(3);
        sb_cmp(locked); sb_cmp(state); sb_cmp(slips);
        q_bad = 1'b0;
        wait_for("t5_wait_relock", 0, 50);
        sb_cmp(locked);

        // T6: abort on the first cycle of a pulse, then restart cleanly
        en = 1'b0; mon = 1'b0; step(1);
        gb_en = 1'b0; q_const = 8'h00;
        clr_mon(0);
        sb_push("t6_alignwd", 0); sb_push("t6_state", 0); sb_push("t6_slips", 0); sb_push("t6_pulses", 1);
        sb_push("t6_restart_state", 1); sb_push("t6_restart_slips", 0);
        sb_push("t6_lock_slips", 0); sb_push("t6_lock_pulses", 1);
        en = 1'b1;
        wait_for("t6_wait_pulse", 2, 50);
        en = 1'b0;
        step(1);
        sb_cmp(alignwd); sb_cmp(state); sb_cmp(slips);
        step(12);
        sb_cmp(pulse_cnt);
        q_const = PAT; en = 1'b1;
        step(1);
        sb_cmp(state); sb_cmp(slips);
        wait_for("t6_wait_lock", 0, 50);
        sb_cmp(slips); sb_cmp(pulse_cnt);

        check("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
